mqnic_app_axil_master: RTL and testbench
========================================

Name: mqnic_app_axil_master

Overview:
- Single-outstanding AXI-Lite master. It converts a simple command/response stream into AXI-Lite register reads and writes.
- It is the initiator side of the app control register space, i.e. the other end of the host-facing AXI-Lite slave.
- Data-path or management logic uses it to program registers, e.g. the SRC MAC at 0x10/0x14 and the version register at 0x04.
- Each command gets a response with a bounded timeout, so an unresponsive slave never hangs the caller.

Parameters:
- DATA_WIDTH, 32, AXI-Lite data width.
- ADDR_WIDTH, 16, AXI-Lite address width.
- STRB_WIDTH, DATA_WIDTH/8, write strobe width.
- TIMEOUT_CYCLES, 1024, cycles to wait for B/R before declaring a timeout. Must be ≥2.
- CNT_WIDTH, $clog2(TIMEOUT_CYCLES+1), timeout counter width.

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accepted
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  ADDR_WIDTH  byte address
- cmd_data  in  DATA_WIDTH  write data
- cmd_strb  in  STRB_WIDTH  write strobes
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accepted
- rsp_data  out  DATA_WIDTH  read data (0 for writes)
- rsp_resp  out  2  BRESP/RRESP, or 2'b10 on timeout
- rsp_timeout  out  1  transaction timed out
- busy  out  1  state != IDLE
- m_axil_awaddr/awprot/awvalid/awready  out/out/out/in  ADDR_WIDTH/3/1/1  AW channel; awprot tied 3'b000
- m_axil_wdata/wstrb/wvalid/wready  out/out/out/in  DATA_WIDTH/STRB_WIDTH/1/1  W channel
- m_axil_bresp/bvalid/bready  in/in/out  2/1/1  B channel
- m_axil_araddr/arprot/arvalid/arready  out/out/out/in  ADDR_WIDTH/3/1/1  AR channel; arprot tied 3'b000
- m_axil_rdata/rresp/rvalid/rready  in/in/in/out  DATA_WIDTH/2/1/1  R channel

Behaviour:
- Reset values: all valid and ready outputs 0 (awvalid, wvalid, arvalid, bready, rready, rsp_valid). cmd_ready=1 (IDLE). Addr/data/strb/rsp_data/rsp_resp 0. rsp_timeout 0. busy 0. Counter 0. State IDLE.
- A reset mid-transaction returns to IDLE immediately. Any pending AXI valids drop; this is acceptable only under a system-wide reset.
- cmd_ready = (state==IDLE), combinational from state. A command is captured into registers on cmd_valid&&cmd_ready.
- States:
  - IDLE.
  - WR_REQ: awvalid and wvalid both assert in the cycle after capture. Each deasserts independently on its own handshake. AW and W may complete in any order or the same cycle. Exit to WR_RESP when both are done.
  - WR_RESP: bready=1. On bvalid, latch bresp, rsp_data=0, go RSP.
  - RD_REQ: arvalid=1 until arready, then RD_RESP.
  - RD_RESP: rready=1. On rvalid, latch rdata/rresp, go RSP.
  - RSP: rsp_valid=1, outputs stable until rsp_ready, then IDLE.
  - DRAIN: see timeout rules.
- Minimum latency, slave always ready:
  - write: capture T0, AW/W handshake T1, B T2, rsp_valid T3.
  - read: AR T1, R T2, rsp_valid T3.
  - Back-to-back commands: next cmd_ready is asserted the cycle after the rsp handshake.
- Valid/ready rules: AW/W/AR valids never deassert before their handshake. Address, data and strobes are stable while valid.
- Timeout rules:
  - The counter clears on entry to WR_RESP/RD_RESP and increments each cycle in those states.
  - Timeout applies only in WR_RESP/RD_RESP, never in request phases.
  - If the counter reaches TIMEOUT_CYCLES with no B/R, go to RSP with rsp_timeout=1, rsp_resp=2'b10, rsp_data=0.
  - After the rsp handshake of a timed-out transaction, enter DRAIN instead of IDLE.
  - In DRAIN, bready or rready (matching the original direction) stays 1 until the stale response is accepted or another TIMEOUT_CYCLES elapse, then go IDLE. cmd_ready=0 in DRAIN.
- Simultaneous events:
  - B/R arriving in the same cycle the counter hits the limit counts as success; the response wins over the timeout.
  - cmd_valid during RSP is not accepted.
- Non-OKAY responses (SLVERR/DECERR) pass through with rsp_timeout=0.

Test Plan:
- Write 0x0010 data 0x12345678 strb 0xF, slave ready → AW/W at T1 with awaddr=0x0010, wdata=0x12345678; rsp_valid at T3 with rsp_resp=0, rsp_timeout=0.
- Read 0x0004, slave returns 0x20231206 → rsp_data=0x20231206, rsp_resp=0; arvalid held until arready even when arready is delayed 5 cycles.
- Write with wready 3 cycles before awready → wvalid drops after its own handshake, awvalid held; exactly one B accepted, one rsp issued.
- Read, slave never responds, TIMEOUT_CYCLES=16 → rsp_timeout=1, rsp_resp=2'b10, rsp_data=0 at 16 cycles; a late rvalid during DRAIN is consumed; the next command then completes normally.
- rsp_ready held low 10 cycles → rsp_* stable and cmd_ready=0 throughout; rsp_valid low the cycle after rsp_ready rises.
- Assert rst mid-WR_REQ → the next cycle all valids are 0, cmd_ready=1, busy=0, and a new read completes normally.

Source files
------------

// File: rtl/mqnic_app_axil_master.sv
// Single-outstanding AXI-Lite master: turns a command/response stream into register
// reads and writes, with a bounded wait on B/R so a dead slave cannot stall the caller.
module mqnic_app_axil_master #(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 16,
   parameter int STRB_WIDTH     = DATA_WIDTH/8,
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int CNT_WIDTH      = $clog2(TIMEOUT_CYCLES+1)
) (
   input  logic                  clk,
   input  logic                  rst,

   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_data,
   input  logic [STRB_WIDTH-1:0] cmd_strb,

   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_data,
   output logic [1:0]            rsp_resp,
   output logic                  rsp_timeout,
   output logic                  busy,

   output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
   output logic [2:0]            m_axil_awprot,
   output logic                  m_axil_awvalid,
   input  logic                  m_axil_awready,
   output logic [DATA_WIDTH-1:0] m_axil_wdata,
   output logic [STRB_WIDTH-1:0] m_axil_wstrb,
   output logic                  m_axil_wvalid,
   input  logic                  m_axil_wready,
   input  logic [1:0]            m_axil_bresp,
   input  logic                  m_axil_bvalid,
   output logic                  m_axil_bready,
   output logic [ADDR_WIDTH-1:0] m_axil_araddr,
   output logic [2:0]            m_axil_arprot,
   output logic                  m_axil_arvalid,
   input  logic                  m_axil_arready,
   input  logic [DATA_WIDTH-1:0] m_axil_rdata,
   input  logic [1:0]            m_axil_rresp,
   input  logic                  m_axil_rvalid,
   output logic                  m_axil_rready
);

   typedef enum logic [2:0] {
      S_IDLE, S_WR_REQ, S_WR_RESP, S_RD_REQ, S_RD_RESP, S_RSP, S_DRAIN
   } state_t;

   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

   state_t                state_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] data_q;
   logic [STRB_WIDTH-1:0] strb_q;
   logic                  wr_q;
   logic                  awvalid_q;
   logic                  wvalid_q;
   logic                  arvalid_q;
   logic                  bready_q;
   logic                  rready_q;
   logic                  rsp_valid_q;
   logic [DATA_WIDTH-1:0] rsp_data_q;
   logic [1:0]            rsp_resp_q;
   logic                  rsp_timeout_q;
   logic [CNT_WIDTH-1:0]  cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         addr_q        <= '0;
         data_q        <= '0;
         strb_q        <= '0;
         wr_q          <= 1'b0;
         awvalid_q     <= 1'b0;
         wvalid_q      <= 1'b0;
         arvalid_q     <= 1'b0;
         bready_q      <= 1'b0;
         rready_q      <= 1'b0;
         rsp_valid_q   <= 1'b0;
         rsp_data_q    <= '0;
         rsp_resp_q    <= 2'b00;
         rsp_timeout_q <= 1'b0;
         cnt_q         <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (cmd_valid) begin
                  addr_q <= cmd_addr;
                  data_q <= cmd_data;
                  strb_q <= cmd_strb;
                  wr_q   <= cmd_write;
                  if (cmd_write) begin
                     awvalid_q <= 1'b1;
                     wvalid_q  <= 1'b1;
                     state_q   <= S_WR_REQ;
                  end else begin
                     arvalid_q <= 1'b1;
                     state_q   <= S_RD_REQ;
                  end
               end
            end
            S_WR_REQ: begin
               // AW and W retire independently; leave once neither is still pending
               if (m_axil_awready) awvalid_q <= 1'b0;
               if (m_axil_wready)  wvalid_q  <= 1'b0;
               if ((!awvalid_q || m_axil_awready) && (!wvalid_q || m_axil_wready)) begin
                  bready_q <= 1'b1;
                  cnt_q    <= '0;
                  state_q  <= S_WR_RESP;
               end
            end
            S_WR_RESP: begin
               if (m_axil_bvalid) begin
                  bready_q      <= 1'b0;
                  rsp_valid_q   <= 1'b1;
                  rsp_data_q    <= '0;
                  rsp_resp_q    <= m_axil_bresp;
                  rsp_timeout_q <= 1'b0;
                  state_q       <= S_RSP;
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
                  if (cnt_q == CNT_LAST) begin
                     bready_q      <= 1'b0;
                     rsp_valid_q   <= 1'b1;
                     rsp_data_q    <= '0;
                     rsp_resp_q    <= 2'b10;
                     rsp_timeout_q <= 1'b1;
                     state_q       <= S_RSP;
                  end
               end
            end
            S_RD_REQ: begin
               if (m_axil_arready) begin
                  arvalid_q <= 1'b0;
                  rready_q  <= 1'b1;
                  cnt_q     <= '0;
                  state_q   <= S_RD_RESP;
               end
            end
            S_RD_RESP: begin
               if (m_axil_rvalid) begin
                  rready_q      <= 1'b0;
                  rsp_valid_q   <= 1'b1;
                  rsp_data_q    <= m_axil_rdata;
                  rsp_resp_q    <= m_axil_rresp;
                  rsp_timeout_q <= 1'b0;
                  state_q       <= S_RSP;
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
                  if (cnt_q == CNT_LAST) begin
                     rready_q      <= 1'b0;
                     rsp_valid_q   <= 1'b1;
                     rsp_data_q    <= '0;
                     rsp_resp_q    <= 2'b10;
                     rsp_timeout_q <= 1'b1;
                     state_q       <= S_RSP;
                  end
               end
            end
            S_RSP: begin
               if (rsp_ready) begin
                  rsp_valid_q   <= 1'b0;
                  rsp_timeout_q <= 1'b0;
                  // a timed-out slave may still answer later; soak that up before reuse
                  if (rsp_timeout_q) begin
                     cnt_q    <= '0;
                     bready_q <= wr_q;
                     rready_q <= !wr_q;
                     state_q  <= S_DRAIN;
                  end else begin
                     state_q <= S_IDLE;
                  end
               end
            end
            S_DRAIN: begin
               if ((wr_q ? m_axil_bvalid : m_axil_rvalid) || cnt_q == CNT_LAST) begin
                  bready_q <= 1'b0;
                  rready_q <= 1'b0;
                  state_q  <= S_IDLE;
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign cmd_ready      = (state_q == S_IDLE);
   assign busy           = (state_q != S_IDLE);
   assign rsp_valid      = rsp_valid_q;
   assign rsp_data       = rsp_data_q;
   assign rsp_resp       = rsp_resp_q;
   assign rsp_timeout    = rsp_timeout_q;
   assign m_axil_awaddr  = addr_q;
   assign m_axil_awprot  = 3'b000;
   assign m_axil_awvalid = awvalid_q;
   assign m_axil_wdata   = data_q;
   assign m_axil_wstrb   = strb_q;
   assign m_axil_wvalid  = wvalid_q;
   assign m_axil_bready  = bready_q;
   assign m_axil_araddr  = addr_q;
   assign m_axil_arprot  = 3'b000;
   assign m_axil_arvalid = arvalid_q;
   assign m_axil_rready  = rready_q;

endmodule

// File: tb/tb_mqnic_app_axil_master.sv
// Bench for mqnic_app_axil_master: a cycle-level AXI-Lite slave with per-transaction delays,
// checked against a transaction-level model of memory contents, responses and latency.
module tb_mqnic_app_axil_master;
   localparam int DW    = 32;
   localparam int AW    = 16;
   localparam int SW    = 4;
   localparam int TO    = 16;
   localparam int NEVER = 100000;

   logic          clk;
   logic          rst;
   logic          cmd_valid, cmd_ready, cmd_write;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_data;
   logic [SW-1:0] cmd_strb;
   logic          rsp_valid, rsp_ready, rsp_timeout, busy;
   logic [DW-1:0] rsp_data;
   logic [1:0]    rsp_resp;
   logic [AW-1:0] awaddr, araddr;
   logic [2:0]    awprot, arprot;
   logic          awvalid, awready, wvalid, wready, bvalid, bready;
   logic          arvalid, arready, rvalid, rready;
   logic [DW-1:0] wdata, rdata;
   logic [SW-1:0] wstrb;
   logic [1:0]    bresp, rresp;

   mqnic_app_axil_master #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_strb(cmd_strb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout), .busy(busy),
      .m_axil_awaddr(awaddr), .m_axil_awprot(awprot), .m_axil_awvalid(awvalid),
      .m_axil_awready(awready), .m_axil_wdata(wdata), .m_axil_wstrb(wstrb),
      .m_axil_wvalid(wvalid), .m_axil_wready(wready), .m_axil_bresp(bresp),
      .m_axil_bvalid(bvalid), .m_axil_bready(bready), .m_axil_araddr(araddr),
      .m_axil_arprot(arprot), .m_axil_arvalid(arvalid), .m_axil_arready(arready),
      .m_axil_rdata(rdata), .m_axil_rresp(rresp), .m_axil_rvalid(rvalid),
      .m_axil_rready(rready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int txn_id   = 0;
   logic [31:0] slave_mem [16];
   logic [31:0] model_mem [16];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Entered and left on a negedge with the master idle.
   task automatic run_txn(input bit wr, input logic [15:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int dly_a, input int dly_w,
                          input int dly_r, input logic [1:0] code, input int hold);
      bit exp_to;
      logic [31:0] exp_data;
      logic [1:0]  exp_resp;
      int exp_hs, exp_rsp_k;
      bit aw_got = 0, w_got = 0, ar_got = 0, aw_pend = 0, w_pend = 0, ar_pend = 0;
      bit r_pend = 0, rsp_pend = 0, rsp_done = 0, in_resp = 0, done = 0;
      bit prev_awv = 0, prev_wv = 0, prev_arv = 0;
      int aw_wait = 0, w_wait = 0, ar_wait = 0, r_wait = 0, rsp_wait = 0;
      int rsp_k = -1, hs_cnt = 0;
      logic [15:0] s_addr = '0;
      logic [31:0] s_wdata = '0;
      logic [3:0]  s_wstrb = '0;

      // transaction-level expectation
      exp_to   = (dly_r >= TO);
      exp_resp = exp_to ? 2'b10 : code;
      exp_hs   = (dly_r < NEVER) ? 1 : 0;
      if (wr) begin
         exp_data = '0;
         for (int b = 0; b < 4; b++)
            if (strb[b]) model_mem[addr[5:2]][8*b +: 8] = data[8*b +: 8];
      end else begin
         exp_data = exp_to ? 32'd0 : model_mem[addr[5:2]];
      end

      check("cmd_ready_idle", {63'd0, cmd_ready}, 64'd1);
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_data = data; cmd_strb = strb;
      exp_rsp_k = -1;

      for (int k = 0; k < 400 && !done; k++) begin
         @(negedge clk);
         if (k == 0) begin
            cmd_valid = 1'b0;
            cmd_addr  = 16'($urandom);
            cmd_data  = $urandom;
            cmd_strb  = 4'($urandom);
         end
         if (aw_pend) aw_got = 1;
         if (w_pend)  w_got  = 1;
         if (ar_pend) ar_got = 1;
         aw_pend = 0; w_pend = 0; ar_pend = 0;
         if (r_pend) begin
            hs_cnt++; r_pend = 0; bvalid = 1'b0; rvalid = 1'b0;
         end
         if (rsp_pend) begin
            rsp_pend = 0; rsp_done = 1; rsp_ready = 1'b0;
            check("rsp_valid_drop", {63'd0, rsp_valid}, 64'd0);
         end

         if (prev_awv && !aw_got) check("awvalid_hold", {63'd0, awvalid}, 64'd1);
         if (prev_wv  && !w_got)  check("wvalid_hold",  {63'd0, wvalid},  64'd1);
         if (prev_arv && !ar_got) check("arvalid_hold", {63'd0, arvalid}, 64'd1);
         if (!in_resp && aw_got)  check("awvalid_drop", {63'd0, awvalid}, 64'd0);
         if (!in_resp && w_got)   check("wvalid_drop",  {63'd0, wvalid},  64'd0);

         if (!in_resp && (wr ? (aw_got && w_got) : ar_got)) begin
            in_resp   = 1;
            exp_rsp_k = k + (exp_to ? TO : dly_r + 1);
            if (wr)
               for (int b = 0; b < 4; b++)
                  if (s_wstrb[b]) slave_mem[s_addr[5:2]][8*b +: 8] = s_wdata[8*b +: 8];
         end

         // request channels
         if (wr && awvalid) begin
            check("awaddr", {48'd0, awaddr}, {48'd0, addr});
            awready = (aw_wait >= dly_a); aw_wait++;
         end else awready = 1'b0;
         if (wr && wvalid) begin
            check("wdata", {32'd0, wdata}, {32'd0, data});
            check("wstrb", {60'd0, wstrb}, {60'd0, strb});
            wready = (w_wait >= dly_w); w_wait++;
         end else wready = 1'b0;
         if (!wr && arvalid) begin
            check("araddr", {48'd0, araddr}, {48'd0, addr});
            arready = (ar_wait >= dly_a); ar_wait++;
         end else arready = 1'b0;
         aw_pend = awvalid && awready; if (aw_pend) s_addr = awaddr;
         w_pend  = wvalid && wready;   if (w_pend) begin s_wdata = wdata; s_wstrb = wstrb; end
         ar_pend = arvalid && arready; if (ar_pend) s_addr = araddr;
         prev_awv = awvalid; prev_wv = wvalid; prev_arv = arvalid;

         // response channel, held until accepted
         if (in_resp && hs_cnt == 0) begin
            if (r_wait >= dly_r) begin
               if (wr) begin
                  bvalid = 1'b1; bresp = code;
               end else begin
                  rvalid = 1'b1; rresp = code; rdata = slave_mem[s_addr[5:2]];
               end
            end
            r_wait++;
         end
         r_pend = wr ? (bvalid && bready) : (rvalid && rready);

         if (rsp_valid) begin
            if (rsp_k < 0) begin
               rsp_k = k;
               check("rsp_latency", 64'(rsp_k), 64'(exp_rsp_k));
            end
            check("rsp_data",    {32'd0, rsp_data},    {32'd0, exp_data});
            check("rsp_resp",    {62'd0, rsp_resp},    {62'd0, exp_resp});
            check("rsp_timeout", {63'd0, rsp_timeout}, {63'd0, exp_to});
            check("cmd_ready_in_rsp", {63'd0, cmd_ready}, 64'd0);
            rsp_ready = (rsp_wait >= hold); rsp_wait++;
            rsp_pend  = rsp_ready;
         end
         if (rsp_done && cmd_ready) done = 1;
      end

      check("txn_complete", {63'd0, done}, 64'd1);
      check("resp_accepted", 64'(hs_cnt), 64'(exp_hs));
      awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0; rsp_ready = 0;
      $display("txn %0d %s addr=0x%04h exp_data=0x%08h exp_resp=%0d exp_to=%0d lat=%0d",
               txn_id, wr ? "WR" : "RD", addr, exp_data, exp_resp, exp_to, rsp_k);
      txn_id++;
   endtask

   initial begin
      logic [31:0] v;
      logic [3:0]  idx;
      int          sel, dr;

      rst = 1'b1; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_data = '0; cmd_strb = '0;
      rsp_ready = 0; awready = 0; wready = 0; bvalid = 0; bresp = '0;
      arready = 0; rvalid = 0; rdata = '0; rresp = '0;
      for (int i = 0; i < 16; i++) begin
         v = $urandom; slave_mem[i] = v; model_mem[i] = v;
      end
      slave_mem[1] = 32'h20231206; model_mem[1] = 32'h20231206;

      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
      check("rst_busy",      {63'd0, busy}, 64'd0);
      check("rst_valids",    {58'd0, awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 64'd0);
      check("rst_rsp",       {29'd0, rsp_data, rsp_resp, rsp_timeout}, 64'd0);
      check("rst_addr",      {32'd0, awaddr, araddr}, 64'd0);

      // directed cases
      run_txn(1, 16'h0010, 32'h12345678, 4'hF, 0, 0, 0, 2'b00, 0);
      run_txn(0, 16'h0004, 32'h0,        4'h0, 5, 0, 0, 2'b00, 0);
      run_txn(1, 16'h0014, 32'hCAFEF00D, 4'h5, 3, 0, 1, 2'b00, 0);
      run_txn(0, 16'h0014, 32'h0,        4'h0, 0, 0, NEVER, 2'b00, 0);
      run_txn(0, 16'h0008, 32'h0,        4'h0, 0, 0, TO + 4, 2'b00, 0);
      run_txn(0, 16'h0010, 32'h0,        4'h0, 0, 0, 0, 2'b00, 0);
      run_txn(0, 16'h0004, 32'h0,        4'h0, 0, 0, 2, 2'b00, 10);
      run_txn(1, 16'h0020, 32'hA5A5A5A5, 4'hC, 1, 2, TO - 1, 2'b10, 0);
      run_txn(1, 16'h0024, 32'h5A5A5A5A, 4'hF, 0, 0, TO, 2'b00, 1);
      run_txn(0, 16'h0020, 32'h0,        4'h0, 0, 0, 0, 2'b11, 0);

      // randomized traffic
      for (int n = 0; n < 40; n++) begin
         idx = 4'($urandom_range(0, 15));
         sel = int'($urandom_range(0, 9));
         if (sel < 6)       dr = int'($urandom_range(0, 4));
         else if (sel == 6) dr = TO - 1;
         else if (sel == 7) dr = TO;
         else if (sel == 8) dr = TO + int'($urandom_range(1, 6));
         else               dr = NEVER;
         run_txn(1'($urandom), {10'd0, idx, 2'b00}, $urandom, 4'($urandom),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), dr,
                 2'($urandom), int'($urandom_range(0, 3)));
      end

      // reset while a write is stuck in its request phase
      cmd_valid = 1; cmd_write = 1; cmd_addr = 16'h0030; cmd_data = 32'hDEADBEEF; cmd_strb = 4'hF;
      @(negedge clk);
      cmd_valid = 0;
      check("pre_rst_busy", {63'd0, busy}, 64'd1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst_valids", {58'd0, awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 64'd0);
      check("midrst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
      check("midrst_busy", {63'd0, busy}, 64'd0);
      run_txn(0, 16'h0004, 32'h0, 4'h0, 1, 0, 1, 2'b00, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
